// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one combinational 32-bit ALU between two requesters.
// Accepts one op at a time, registers ALU inputs, captures the result and holds it under backpressure.
module alu_arbiter #(
    parameter int                DATA_W       = 32,
    parameter int                CTRL_W       = 4,
    parameter logic [CTRL_W-1:0] DEFAULT_CTRL = 4'b0010
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_zero,
    input  logic              alu_ovf,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic [2:0]        rsp_flags,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    logic   last_grant;
    logic   grant_id;
    logic   accept;

    // A lone valid wins outright; a tie goes to the port that did not win last time.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        grant_id = req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end
    end

    assign accept = (state == IDLE) && (req0_valid || req1_valid) && !reset;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)    next_state = EXEC;
            EXEC:                   next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = accept && !grant_id;
        req1_ready = accept && grant_id;
        rsp_valid  = (state == RESP);
        busy       = (state != IDLE);
    end

    // last_grant also identifies the op in flight, since it only moves on an accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= DEFAULT_CTRL;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_flags  <= '0;
        end else begin
            if (accept) begin
                last_grant <= grant_id;
                alu_a      <= grant_id ? req1_a    : req0_a;
                alu_b      <= grant_id ? req1_b    : req0_b;
                alu_ctrl   <= grant_id ? req1_ctrl : req0_ctrl;
            end
            if (state == EXEC) begin
                rsp_id    <= last_grant;
                rsp_data  <= alu_result;
                rsp_flags <= {alu_carry, alu_zero, alu_ovf};
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: behavioural ALU, hand-computed expectations, immediate assertions.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl;
    logic        alu_carry, alu_zero, alu_ovf;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_flags;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .alu_zero(alu_zero), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .busy(busy)
    );

    // Combinational ALU stand-in: 0010 add, 0110 sub, 0000 and, 0001 or.
    logic [32:0] wide;
    always_comb begin
        wide       = '0;
        alu_result = '0;
        alu_carry  = 1'b0;
        alu_ovf    = 1'b0;
        case (alu_ctrl)
            4'b0010: begin
                wide       = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = wide[31:0];
                alu_carry  = wide[32];
                alu_ovf    = (alu_a[31] == alu_b[31]) && (wide[31] != alu_a[31]);
            end
            4'b0110: begin
                wide       = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_result = wide[31:0];
                alu_carry  = wide[32];
                alu_ovf    = (alu_a[31] != alu_b[31]) && (wide[31] != alu_a[31]);
            end
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Waits (bounded) for the given port's ready; entered at a negedge, returns 1 time unit after one.
    task automatic wait_grant(input bit port, input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (port ? req1_ready : req0_ready) begin
                got = 1'b1;
                break;
            end
            step();
        end
        check({tag, "_grant"}, {31'd0, got}, 32'd1);
        check({tag, "_other_ready"}, {31'd0, port ? req0_ready : req1_ready}, 32'd0);
    endtask

    // Full transaction with rsp_ready high: grant, EXEC inputs, response, return to IDLE.
    task automatic do_op(input bit port, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] ctrl, input logic [31:0] exp_data,
                         input logic [2:0] exp_flags, input string tag);
        if (port) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = ctrl;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = ctrl;
        end
        wait_grant(port, tag);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check({tag, "_alu_a"}, alu_a, a);
        check({tag, "_alu_b"}, alu_b, b);
        check({tag, "_alu_ctrl"}, {28'd0, alu_ctrl}, {28'd0, ctrl});
        check({tag, "_exec_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_exec_no_rsp"}, {31'd0, rsp_valid}, 32'd0);
        step();
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, "_rsp_id"}, {31'd0, rsp_id}, {31'd0, port});
        check({tag, "_rsp_data"}, rsp_data, exp_data);
        check({tag, "_rsp_flags"}, {29'd0, rsp_flags}, {29'd0, exp_flags});
        step();
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_idle_rsp"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    // Both ports valid throughout; served order must alternate starting with port 0.
    task automatic tie_run(input int n_ops, input string tag);
        bit found;
        req0_a = 32'd100; req0_b = 32'd1; req0_ctrl = 4'b0010; req0_valid = 1'b1;
        req1_a = 32'd101; req1_b = 32'd1; req1_ctrl = 4'b0010; req1_valid = 1'b1;
        for (int i = 0; i < n_ops; i++) begin
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                #1;
                if (req0_ready || req1_ready) begin
                    found = 1'b1;
                    break;
                end
                step();
            end
            check({tag, "_grant_seen"}, {31'd0, found}, 32'd1);
            check({tag, "_order"}, {31'd0, req1_ready}, i % 2);
            check({tag, "_one_ready"}, {31'd0, req0_ready & req1_ready}, 32'd0);
            step();
            if (i % 2 == 0) req0_a = 32'(100 + i + 2);
            else            req1_a = 32'(100 + i + 2);
            step();
            check({tag, "_rsp_id"}, {31'd0, rsp_id}, i % 2);
            check({tag, "_rsp_data"}, rsp_data, 32'(100 + i + 1));
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_ctrl = 4'b0010;
        req1_a = '0; req1_b = '0; req1_ctrl = 4'b0010;
        step();
        step();
        #1;
        check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'h2);
        check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_flags", {29'd0, rsp_flags}, 32'd0);
        req0_valid = 1'b0;
        step();
        reset = 1'b0;

        do_op(1'b0, 32'd5, 32'd7, 4'b0010, 32'd12, 3'b000, "single");
        check("keep_alu_a", alu_a, 32'd5);
        do_op(1'b1, 32'd3, 32'd3, 4'b0110, 32'd0, 3'b110, "zero");
        do_op(1'b0, 32'h7FFF_FFFF, 32'd1, 4'b0010, 32'h8000_0000, 3'b001, "ovf");
        do_op(1'b1, 32'hF0F0_1234, 32'h0FF0_FFFF, 4'b0000, 32'h00F0_1234, 3'b000, "and");

        // Backpressure: response held four cycles while port 1 waits.
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd3; req0_ctrl = 4'b0110;
        wait_grant(1'b0, "bp");
        step();
        req0_valid = 1'b0;
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd20; req1_b = 32'd22; req1_ctrl = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rsp_data", rsp_data, 32'd7);
            check("bp_rsp_id", {31'd0, rsp_id}, 32'd0);
            check("bp_rsp_flags", {29'd0, rsp_flags}, 32'b100);
            check("bp_no_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        #1;
        check("bp_idle_busy", {31'd0, busy}, 32'd0);
        check("bp_idle_rsp", {31'd0, rsp_valid}, 32'd0);
        check("bp_next_grant", {31'd0, req1_ready}, 32'd1);
        step();
        req1_valid = 1'b0;
        step();
        check("bp_second_data", rsp_data, 32'd42);
        check("bp_second_id", {31'd0, rsp_id}, 32'd1);
        step();

        // Tie straight out of reset: port 0 first, then strict alternation.
        reset = 1'b1;
        step();
        reset = 1'b0;
        tie_run(6, "tie");

        // Reset in EXEC of a port-0 op: dropped, and last_grant back to 1.
        step();
        req0_valid = 1'b1; req0_a = 32'hFF; req0_b = 32'h0F; req0_ctrl = 4'b0000;
        wait_grant(1'b0, "mid");
        step();
        req0_valid = 1'b0;
        check("mid_exec_ctrl", {28'd0, alu_ctrl}, 32'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_alu_ctrl", {28'd0, alu_ctrl}, 32'h2);
        check("mid_alu_a", alu_a, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        tie_run(2, "mid_tie");

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
